mv_systolic_array: RTL
======================

// Module: mv_systolic_array
// PURPOSE
//   Parametrised matrix-vector multiplier MV = M x V using a DIM-long linear systolic chain of MAC PEs.
//   One operand set is accepted per job over a valid/ready handshake; results are returned on an output handshake.
//   Adds wide accumulators, skew control, back-pressure, stall and abort.
//   Sits between the operand buffers and the vector post-processing stage.
// PARAMETERS
//   DIM    4   matrix dimension / PE count (>=2)
//   WIDTH  8   unsigned element width of M and V
//   ACC_W  2*WIDTH+$clog2(DIM)   per-row accumulator width (never overflows)
//   OUT_W  16  width of each result element on mv_o
// PORTS
//   clk        in   1              rising-edge clock
//   rst        in   1              async active-low reset
//   en         in   1              clock enable; 0 freezes all state (stall)
//   clr        in   1              sync abort: return to IDLE, drop job
//   in_valid   in   1              operand set valid
//   in_ready   out  1              block can accept operands
//   m_i        in   DIM*DIM*WIDTH  M[r][c] at bits [(r*DIM+c)*WIDTH +: WIDTH]
//   v_i        in   DIM*WIDTH      V[c] at bits [c*WIDTH +: WIDTH]
//   out_valid  out  1              mv_o holds a complete result
//   out_ready  in   1              downstream accepts result
//   mv_o       out  DIM*OUT_W      MV[r] at bits [r*OUT_W +: OUT_W]
//   busy       out  1              state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, mv_o=0, busy=0, all PE accumulators and pipes=0.
//   FSM IDLE->COMPUTE->OUT->IDLE.
//   in_ready = (state==IDLE); transfer = in_valid&in_ready&en.
//   IDLE: on transfer, latch m_i/v_i, clear accumulators and cycle count k=0, go to COMPUTE.
//   COMPUTE: V streams into PE0 and shifts one PE per cycle.
//     PE r sees V[c] and M[r][c] at k=r+c; acc_r += M[r][c]*V[c], full ACC_W precision.
//     Total 2*DIM-1 compute cycles (k=0..2*DIM-2); then mv_o is loaded, out_valid=1, state=OUT.
//   Latency: out_valid rises exactly 2*DIM enabled cycles after the transfer edge (DIM=4 -> 8).
//   OUT: mv_o and out_valid are held stable until out_ready=1.
//     On out_ready: out_valid=0 next edge, state=IDLE; in_ready rises that same edge (no same-cycle accept).
//   en=0: no state, counter, PE or output changes, including during an OUT handshake.
//     in_ready and out_valid keep their values but no transfer completes.
//   clr=1 (when en=1): next edge state=IDLE, out_valid=0, accumulators=0; mv_o retains its last value.
//     clr has priority over any handshake in the same cycle.
//   Async rst mid-job: immediate return to the reset values; the job is lost.
//   Inputs are ignored outside the IDLE transfer cycle; m_i/v_i may change freely afterwards.
// CONFIGURATION
//   MV_SAT_EN defined:   MV[r] = (acc_r > 2^OUT_W-1) ? 2^OUT_W-1 : acc_r.
//   MV_SAT_EN undefined: MV[r] = acc_r[OUT_W-1:0] (wrap-around).
//   If OUT_W>=ACC_W, the result is zero-extended in both modes.
// STRUCTURE
//   Package mv_pkg: state enum (IDLE, COMPUTE, OUT), acc_w()/cnt_w() constant functions, sat function.
//   Sub-module mv_pe: registered V pass-through, MAC accumulator, en and clear inputs; generated DIM times.
//   Top holds the FSM, skew counter, operand latch, per-row M element select and output register.
// TESTING (DIM=4, WIDTH=8, OUT_W=16)
//   M=identity, V={1,2,3,4} -> MV={1,2,3,4}; out_valid exactly 8 cycles after accept.
//   M[r][c]=r*4+c+1, V={1,1,1,1} -> MV={10,26,42,58}.
//   All M=V=255 -> acc=260100; mv_o = 65535 with MV_SAT_EN, 63492 without.
//   out_ready=0 for 5 cycles -> mv_o/out_valid stable, in_ready=0.
//     Then out_ready=1 -> IDLE, and the next job is accepted one cycle later.
//   en=0 for 3 cycles mid-COMPUTE -> results identical; latency extended by exactly 3.
//   rst or clr asserted at k=3 -> in_ready=1 and out_valid=0; a new job (identity, V={9,8,7,6}) gives {9,8,7,6}.

Source files
------------

// File: rtl/mv_pkg.sv
// Shared types and constant helpers for the matrix-vector systolic multiplier.
package mv_pkg;

   typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

   function automatic int acc_w(input int dim, input int width);
      return 2 * width + $clog2(dim);
   endfunction

   // Skew counter runs k = 0 .. 2*dim-1 (last value is the drain cycle).
   function automatic int cnt_w(input int dim);
      return $clog2(2 * dim);
   endfunction

   function automatic logic [63:0] sat_u(input logic [63:0] x, input int out_w);
      logic [63:0] lim;
      if (out_w >= 64) return x;
      lim = (64'd1 << out_w) - 64'd1;
      return (x > lim) ? lim : x;
   endfunction

endpackage

// File: rtl/mv_if.sv
// Operand/result handshake bundle between the operand buffers, the multiplier and post-processing.
interface mv_if #(
   parameter int DIM   = 4,
   parameter int WIDTH = 8,
   parameter int OUT_W = 16
);
   logic                       in_valid;
   logic                       in_ready;
   logic [DIM*DIM*WIDTH-1:0]   m_i;
   logic [DIM*WIDTH-1:0]       v_i;
   logic                       out_valid;
   logic                       out_ready;
   logic [DIM*OUT_W-1:0]       mv_o;

   modport slave (
      input  in_valid, m_i, v_i, out_ready,
      output in_ready, out_valid, mv_o
   );

   modport master (
      output in_valid, m_i, v_i, out_ready,
      input  in_ready, out_valid, mv_o
   );
endinterface

// File: rtl/mv_pe.sv
// One systolic MAC processing element: registered V pass-through plus a full-precision accumulator.
module mv_pe
   import mv_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ACC_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic             step,
   input  logic [WIDTH-1:0] v_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] v_o,
   output logic [ACC_W-1:0] acc_o
);

   logic [WIDTH-1:0] v_q, v_d;
   logic [ACC_W-1:0] acc_q, acc_d;

   always_comb begin
      v_d   = v_q;
      acc_d = acc_q;
      if (en) begin
         if (clear) begin
            v_d   = '0;
            acc_d = '0;
         end else if (step) begin
            v_d   = v_i;
            acc_d = acc_q + ACC_W'(m_i) * ACC_W'(v_i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q   <= '0;
         acc_q <= '0;
      end else begin
         v_q   <= v_d;
         acc_q <= acc_d;
      end
   end

   assign v_o   = v_q;
   assign acc_o = acc_q;

endmodule

// File: rtl/mv_systolic_array.sv
// Matrix-vector multiplier MV = M x V on a DIM-long linear systolic MAC chain with in/out handshakes.
// Define MV_SAT_EN to saturate each result element to OUT_W bits; otherwise results wrap.
module mv_systolic_array
   import mv_pkg::*;
#(
   parameter int DIM   = 4,
   parameter int WIDTH = 8,
   parameter int ACC_W = acc_w(DIM, WIDTH),
   parameter int OUT_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   mv_if.slave  bus,
   output logic busy
);

   localparam int            CW     = cnt_w(DIM);
   localparam logic [CW-1:0] K_LAST = CW'(2 * DIM - 1);

   state_t               state_q, state_d;
   logic [CW-1:0]        k_q, k_d;
   logic [WIDTH-1:0]     m_q [DIM][DIM];
   logic [WIDTH-1:0]     m_d [DIM][DIM];
   logic [WIDTH-1:0]     v_q [DIM];
   logic [WIDTH-1:0]     v_d [DIM];
   logic [DIM*OUT_W-1:0] mv_q, mv_d;

   logic                 pe_clear, pe_step;
   logic [WIDTH-1:0]     v_feed;
   logic [WIDTH-1:0]     m_sel  [DIM];
   logic [WIDTH-1:0]     pe_v_o [DIM];
   logic [ACC_W-1:0]     acc    [DIM];
   logic                 unused_v_tail;

   function automatic logic [OUT_W-1:0] shape(input logic [ACC_W-1:0] a);
`ifdef MV_SAT_EN
      return OUT_W'(sat_u(64'(a), OUT_W));
`else
      return OUT_W'(64'(a));
`endif
   endfunction

   // Skew: PE r multiplies M[r][c] with V[c] at k = r + c; V[k] enters PE0.
   always_comb begin
      v_feed = '0;
      for (int c = 0; c < DIM; c++) begin
         if (int'(k_q) == c) v_feed = v_q[c];
      end
      for (int r = 0; r < DIM; r++) begin
         m_sel[r] = '0;
         for (int c = 0; c < DIM; c++) begin
            if (int'(k_q) == r + c) m_sel[r] = m_q[r][c];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      m_d      = m_q;
      v_d      = v_q;
      mv_d     = mv_q;
      pe_clear = 1'b0;
      pe_step  = 1'b0;
      if (en) begin
         if (clr) begin
            state_d  = IDLE;
            k_d      = '0;
            pe_clear = 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.in_valid) begin
                     for (int r = 0; r < DIM; r++) begin
                        for (int c = 0; c < DIM; c++) begin
                           m_d[r][c] = bus.m_i[(r*DIM+c)*WIDTH +: WIDTH];
                        end
                     end
                     for (int c = 0; c < DIM; c++) begin
                        v_d[c] = bus.v_i[c*WIDTH +: WIDTH];
                     end
                     k_d      = '0;
                     pe_clear = 1'b1;
                     state_d  = COMPUTE;
                  end
               end
               COMPUTE: begin
                  pe_step = 1'b1;
                  // The final k is a drain cycle: the last products are already in the accumulators.
                  if (k_q == K_LAST) begin
                     for (int r = 0; r < DIM; r++) begin
                        mv_d[r*OUT_W +: OUT_W] = shape(acc[r]);
                     end
                     k_d     = '0;
                     state_d = OUT;
                  end else begin
                     k_d = k_q + CW'(1);
                  end
               end
               OUT: begin
                  if (bus.out_ready) state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         mv_q    <= '0;
         for (int r = 0; r < DIM; r++) begin
            v_q[r] <= '0;
            for (int c = 0; c < DIM; c++) m_q[r][c] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         mv_q    <= mv_d;
         m_q     <= m_d;
         v_q     <= v_d;
      end
   end

   for (genvar r = 0; r < DIM; r++) begin : g_pe
      logic [WIDTH-1:0] pe_v_in;
      if (r == 0) begin : g_head
         assign pe_v_in = v_feed;
      end else begin : g_link
         assign pe_v_in = pe_v_o[r-1];
      end
      mv_pe #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_pe (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .clear (pe_clear),
         .step  (pe_step),
         .v_i   (pe_v_in),
         .m_i   (m_sel[r]),
         .v_o   (pe_v_o[r]),
         .acc_o (acc[r])
      );
   end

   // The last PE's V output has no consumer.
   assign unused_v_tail = ^pe_v_o[DIM-1];

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == OUT);
   assign bus.mv_o      = mv_q;
   assign busy          = (state_q != IDLE);

endmodule
